// File: rtl/gpio_mul_engine_pkg.sv
// gpio_mul_engine_pkg: register map, STATUS bit positions and FSM states shared by the multiply engine.
package gpio_mul_engine_pkg;
    localparam logic [15:0] ADDR_A1     = 16'h0108;
    localparam logic [15:0] ADDR_A2     = 16'h0110;
    localparam logic [15:0] ADDR_W      = 16'h0118;
    localparam logic [15:0] ADDR_L      = 16'h0120;
    localparam logic [15:0] ADDR_STATUS = 16'h0128;
    localparam logic [15:0] ADDR_CTRL   = 16'h0130;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_ERR  = 3;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/gpio_mul_engine_mul.sv
// mul_seq: LSB-first shift-add multiplier, one multiplier bit per cycle while busy.
module mul_seq #(
    parameter int OP_W = 24
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                start,
    input  logic                busy,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic [2*OP_W-1:0]   product
);
    logic [2*OP_W-1:0] mcand;
    logic [OP_W-1:0]   mplier;

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (start) begin
            mcand   <= {{OP_W{1'b0}}, a};
            mplier  <= b;
            product <= '0;
        end else if (busy) begin
            product <= mplier[0] ? product + mcand : product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
        end
endmodule

// File: rtl/gpio_mul_engine.sv
// gpio_mul_engine: bus-mapped sequential multiplier with completion counter and GPIO capture.
// Define GPIO_MUL_ENGINE_POPCNT_EN to compile in the product popcount (L register).
module gpio_mul_engine #(
    parameter int OP_W   = 24,
    parameter int RES_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [15:0]       saddress,
    input  logic              srd,
    input  logic              swr,
    input  logic [DATA_W-1:0] sdata_in,
    output logic [DATA_W-1:0] sdata_out,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic              gpio_latch,
    output logic [DATA_W-1:0] gpio_out,
    output logic [DATA_W-1:0] gpio_in_s_insp
);
    import gpio_mul_engine_pkg::*;

    localparam int CW = $clog2(OP_W + 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   a1, a2, l_rd, rd_data;
    logic [RES_W-1:0]    w, w_next;
    logic [2*OP_W-1:0]   product;
    logic [3:0]          status;
    logic                done, ovf, err, latch_q, busy, big;
    logic                wr_a1, wr_a2, start, abort, rd_status;
`ifdef GPIO_MUL_ENGINE_POPCNT_EN
    logic [DATA_W-1:0]   l;
    assign l_rd = l;
`else
    assign l_rd = '0;
`endif

    assign busy      = state != IDLE;
    assign wr_a1     = swr && saddress == ADDR_A1;
    assign wr_a2     = swr && saddress == ADDR_A2;
    assign start     = wr_a2 && !busy;
    assign abort     = swr && saddress == ADDR_CTRL && sdata_in[0] && busy;
    assign rd_status = srd && saddress == ADDR_STATUS;
    assign big       = (product >> RES_W) != '0;
    assign w_next    = big ? product[2*OP_W-1 -: RES_W] : product[RES_W-1:0];

    always_comb begin
        status          = '0;
        status[ST_BUSY] = busy;
        status[ST_DONE] = done;
        status[ST_OVF]  = ovf;
        status[ST_ERR]  = err;
        rd_data = saddress == ADDR_A1     ? a1 :
                  saddress == ADDR_A2     ? a2 :
                  saddress == ADDR_W      ? DATA_W'(w) :
                  saddress == ADDR_L      ? l_rd :
                  saddress == ADDR_STATUS ? DATA_W'(status) : '0;
    end

    mul_seq #(.OP_W(OP_W)) u_mul (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .busy    (state == RUN),
        .a       (a1[OP_W-1:0]),
        .b       (sdata_in[OP_W-1:0]),
        .product (product)
    );

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            a1             <= '0;
            a2             <= '0;
            w              <= '0;
            done           <= 1'b0;
            ovf            <= 1'b0;
            err            <= 1'b0;
            latch_q        <= 1'b0;
            sdata_out      <= '0;
            gpio_out       <= '0;
            gpio_in_s_insp <= '0;
`ifdef GPIO_MUL_ENGINE_POPCNT_EN
            l              <= '0;
`endif
        end else begin
            latch_q <= gpio_latch;
            if (gpio_latch && !latch_q) gpio_in_s_insp <= gpio_in;
            if (srd) sdata_out <= rd_data;
            if (wr_a1 && !busy) a1 <= sdata_in;
            if (wr_a2 && !busy) a2 <= sdata_in;
            // a rejected write in the same cycle as a STATUS read keeps err set
            err <= ((wr_a1 || wr_a2) && busy) || (err && !rd_status);
            if (abort) state <= IDLE;
            else
                unique case (state)
                    IDLE: if (start) begin
                        state <= RUN;
                        cnt   <= CW'(OP_W);
                        done  <= 1'b0;
                        ovf   <= 1'b0;
                        w     <= '0;
`ifdef GPIO_MUL_ENGINE_POPCNT_EN
                        l     <= '0;
`endif
                    end
                    RUN: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIN;
                    end
                    FIN: begin
                        state    <= IDLE;
                        w        <= w_next;
                        ovf      <= big;
                        done     <= 1'b1;
                        gpio_out <= gpio_out + 1'b1;
`ifdef GPIO_MUL_ENGINE_POPCNT_EN
                        l        <= DATA_W'($countones(product));
`endif
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: tb/tb_gpio_mul_engine.sv
// tb_gpio_mul_engine: directed and randomized checks of gpio_mul_engine against an arithmetic model.
module tb_gpio_mul_engine;
    localparam int OP_W = 24, RES_W = 32, DATA_W = 32;
    localparam logic [15:0] A1 = 16'h108, A2 = 16'h110, WR = 16'h118, LR = 16'h120, ST = 16'h128, CT = 16'h130;
`ifdef GPIO_MUL_ENGINE_POPCNT_EN
    localparam bit POPEN = 1'b1;
`else
    localparam bit POPEN = 1'b0;
`endif

    logic clk = 1'b0, n_reset = 1'b0, srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
    logic [15:0] saddress = '0;
    logic [DATA_W-1:0] sdata_in = '0, gpio_in = '0, sdata_out, gpio_out, gpio_in_s_insp;
    int errors = 0, checks = 0;
    logic [DATA_W-1:0] exp_cnt = '0;

    gpio_mul_engine #(.OP_W(OP_W), .RES_W(RES_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
        .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
    );

    always #5 clk = ~clk;

    // called at a negedge, returns at the negedge after the write edge
    task automatic bus_write(input logic [15:0] addr, input logic [DATA_W-1:0] data);
        saddress = addr; sdata_in = data; swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [DATA_W-1:0] data);
        saddress = addr; srd = 1'b1;
        @(negedge clk);
        srd = 1'b0;
        data = sdata_out;
    endtask

    function automatic void model(input longint unsigned a, input longint unsigned b,
                                  output logic [DATA_W-1:0] w, output logic [DATA_W-1:0] l, output bit ovf);
        longint unsigned p = a * b;
        ovf = p >= (64'd1 << RES_W);
        w = DATA_W'(ovf ? p >> (2*OP_W - RES_W) : p);
        l = POPEN ? DATA_W'($countones(p)) : '0;
    endfunction

    task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input string tag);
        logic [DATA_W-1:0] ew, el, d;
        bit eo;
        model(a, b, ew, el, eo);
        bus_write(A1, DATA_W'(a));
        bus_write(A2, DATA_W'(b));
        bus_read(ST, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL %s busy_after_start: got %h expected %h", tag, d, 32'h1); end
        repeat (OP_W - 1) @(negedge clk);
        bus_read(ST, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL %s busy_in_fin: got %h expected %h", tag, d, 32'h1); end
        bus_read(ST, d);
        checks++; if (d !== (eo ? 32'h6 : 32'h2)) begin errors++; $display("FAIL %s status_done: got %h expected %h", tag, d, eo ? 32'h6 : 32'h2); end
        exp_cnt++;
        bus_read(WR, d);
        checks++; if (d !== ew) begin errors++; $display("FAIL %s W: got %h expected %h", tag, d, ew); end
        bus_read(LR, d);
        checks++; if (d !== el) begin errors++; $display("FAIL %s L: got %0d expected %0d", tag, d, el); end
        checks++; if (gpio_out !== exp_cnt) begin errors++; $display("FAIL %s gpio_out: got %0d expected %0d", tag, gpio_out, exp_cnt); end
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sdata_out !== '0 || gpio_out !== '0 || gpio_in_s_insp !== '0) begin errors++; $display("FAIL reset_outputs: got %h/%h/%h expected 0/0/0", sdata_out, gpio_out, gpio_in_s_insp); end
        n_reset = 1'b1;
        @(negedge clk);
        bus_read(ST, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
        bus_read(A1, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_a1: got %h expected 0", d); end
    endtask

    task automatic test_basic();
        run_op(24'd3, 24'd5, "basic");
        run_op(24'hFFFFFF, 24'hFFFFFF, "max");
        run_op(24'd0, 24'h123456, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_op(i[0] ? 24'($urandom) : 24'($urandom_range(0, 4095)), 24'($urandom), "random");
    endtask

    task automatic test_err();
        logic [DATA_W-1:0] d;
        bus_write(A1, 32'd7);
        bus_write(A2, 32'd9);
        repeat (2) @(negedge clk);
        bus_write(A1, 32'd1);
        repeat (OP_W - 2) @(negedge clk);
        bus_read(ST, d);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL err_status: got %h expected %h", d, 32'hA); end
        bus_read(ST, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL err_cleared: got %h expected %h", d, 32'h2); end
        exp_cnt++;
        bus_read(WR, d);
        checks++; if (d !== 32'd63) begin errors++; $display("FAIL err_W: got %0d expected 63", d); end
        bus_read(A1, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL err_a1_kept: got %0d expected 7", d); end
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] d;
        bus_write(A1, 32'd100);
        bus_write(A2, 32'd200);
        repeat (3) @(negedge clk);
        bus_write(CT, 32'd1);
        bus_read(ST, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_status: got %h expected 0", d); end
        bus_read(WR, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_W: got %h expected 0", d); end
        repeat (OP_W + 4) @(negedge clk);
        bus_read(ST, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_no_finish: got %h expected 0", d); end
        checks++; if (gpio_out !== exp_cnt) begin errors++; $display("FAIL abort_gpio_out: got %0d expected %0d", gpio_out, exp_cnt); end
        bus_write(CT, 32'd1);
        run_op(24'd11, 24'd13, "after_abort");
    endtask

    task automatic test_regs();
        logic [DATA_W-1:0] d;
        bus_write(A1, 32'h1234);
        saddress = A1; sdata_in = 32'h5678; srd = 1'b1; swr = 1'b1;
        @(negedge clk);
        srd = 1'b0; swr = 1'b0;
        checks++; if (sdata_out !== 32'h1234) begin errors++; $display("FAIL rw_same_cycle: got %h expected %h", sdata_out, 32'h1234); end
        bus_read(A1, d);
        checks++; if (d !== 32'h5678) begin errors++; $display("FAIL rw_written: got %h expected %h", d, 32'h5678); end
        bus_read(16'h0200, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
        bus_write(WR, 32'hDEAD);
        bus_read(WR, d);
        checks++; if (d !== 32'd143) begin errors++; $display("FAIL ro_write_ignored: got %h expected %h", d, 32'd143); end
        bus_read(CT, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL ctrl_read: got %h expected 0", d); end
    endtask

    task automatic test_gpio_latch();
        gpio_latch = 1'b0; gpio_in = 32'hA5A5A5A5;
        repeat (2) @(negedge clk);
        gpio_latch = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (gpio_in_s_insp !== 32'hA5A5A5A5) begin errors++; $display("FAIL latch_capture: got %h expected %h", gpio_in_s_insp, 32'hA5A5A5A5); end
        gpio_in = 32'h12345678;
        repeat (3) @(negedge clk);
        checks++; if (gpio_in_s_insp !== 32'hA5A5A5A5) begin errors++; $display("FAIL latch_held: got %h expected %h", gpio_in_s_insp, 32'hA5A5A5A5); end
        gpio_latch = 1'b0;
        @(negedge clk);
        gpio_latch = 1'b1;
        @(negedge clk);
        checks++; if (gpio_in_s_insp !== 32'h12345678) begin errors++; $display("FAIL latch_second: got %h expected %h", gpio_in_s_insp, 32'h12345678); end
    endtask

    task automatic test_async_reset();
        logic [DATA_W-1:0] d;
        bus_write(A1, 32'd2);
        bus_write(A2, 32'd3);
        bus_read(A1, d);
        repeat (8) @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        checks++; if (sdata_out !== '0 || gpio_out !== '0 || gpio_in_s_insp !== '0) begin errors++; $display("FAIL async_reset_outputs: got %h/%h/%h expected 0/0/0", sdata_out, gpio_out, gpio_in_s_insp); end
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (OP_W + 5) @(negedge clk);
        bus_read(ST, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_no_completion: got %h expected 0", d); end
        bus_read(WR, d);
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_W: got %h expected 0", d); end
        checks++; if (gpio_out !== '0) begin errors++; $display("FAIL reset_gpio_out: got %0d expected 0", gpio_out); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_random();
        test_err();
        test_abort();
        test_regs();
        test_gpio_latch();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpio_mul_engine.md
GPIO_MUL_ENGINE -- requirements
Module: gpio_mul_engine

Interface
REQ-001 The block SHALL have parameter OP_W, default 24, as the operand width in bits.
REQ-002 The block SHALL have parameter RES_W, default 32, as the result register width; the legal range SHALL be OP_W <= RES_W <= 2*OP_W.
REQ-003 The block SHALL have parameter DATA_W, default 32, as the bus and GPIO width.
REQ-004 The block SHALL have ports clk, n_reset, and a bus group:
- clk  in  1  clock.
- n_reset  in  1  reset, asynchronous, active-low.
- saddress  in  16  register address.
- srd  in  1  read strobe, one clk cycle, sampled on clk.
- swr  in  1  write strobe, one clk cycle, sampled on clk.
- sdata_in  in  DATA_W  write data.
- sdata_out  out  DATA_W  registered read data.
REQ-005 The block SHALL have a GPIO group:
- gpio_in  in  DATA_W  GPIO inputs.
- gpio_latch  in  1  capture request, level input.
- gpio_out  out  DATA_W  completed-operation counter.
- gpio_in_s_insp  out  DATA_W  latched gpio_in, for inspection.

Function
REQ-006 Register map (read/write): 0x108 A1 (RW); 0x110 A2 (RW, a write starts the operation); 0x118 W (RO); 0x120 L (RO); 0x128 STATUS (RO); 0x130 CTRL (WO).
- STATUS bits: bit0 busy, bit1 done, bit2 overflow, bit3 err (sticky).
- CTRL: bit0 abort.
REQ-007 Reads of unmapped addresses SHALL return 0; writes to unmapped or read-only addresses SHALL be ignored.
REQ-008 sdata_out SHALL update on the clk edge after srd is sampled, and SHALL hold its value otherwise.
REQ-009 The FSM SHALL have states IDLE, RUN and FIN.
- IDLE→RUN: on an A2 write while not busy.
- RUN→FIN: after exactly OP_W RUN cycles.
- FIN→IDLE: always, after 1 cycle.
REQ-010 RUN SHALL perform a shift-add multiply at one multiplier bit per cycle (LSB first), into a 2*OP_W-bit product.
REQ-011 An A2 write at edge t SHALL give busy=1 from t+1; W, L and done SHALL be valid after edge t+OP_W+1.
REQ-012 On entering RUN, done and overflow SHALL clear, and W and L SHALL be cleared.
REQ-013 In FIN, if product < 2^RES_W then W = product and overflow = 0; otherwise W = product[2*OP_W-1 -: RES_W] and overflow = 1.
REQ-014 In FIN, L SHALL be set to the popcount of the full 2*OP_W-bit product (see REQ-021).
REQ-015 In FIN, done SHALL be set and gpio_out SHALL increment by 1, wrapping from 2^DATA_W-1 to 0.
REQ-016 A write to A1 or A2 while busy SHALL be ignored and SHALL set err; reading STATUS SHALL clear err on the same edge on which sdata_out is loaded.
REQ-017 A CTRL write with bit0=1 while busy SHALL return the FSM to IDLE, leave W, L and done unchanged, and not increment gpio_out; while idle it SHALL have no effect.
REQ-018 When srd and swr are asserted in the same cycle, both SHALL be serviced, and the read SHALL return the pre-write value.
REQ-019 A sampled rising edge of gpio_latch (0 then 1 on consecutive clk edges) SHALL load gpio_in into gpio_in_s_insp.

Reset
REQ-020 Assertion of n_reset SHALL immediately clear all registers, outputs, state and counters (FSM=IDLE, sdata_out=0, gpio_out=0, gpio_in_s_insp=0), including during RUN; deassertion SHALL be synchronised to clk.

Configuration
REQ-021 Macro GPIO_MUL_ENGINE_POPCNT_EN SHALL control the popcount logic.
- Defined: the popcount logic is compiled in and L behaves per REQ-014.
- Undefined: no popcount logic, and L SHALL always read 0.

Structure
REQ-022 A shared package SHALL hold the register address constants, STATUS bit indices, and the FSM state enum.
REQ-023 The shift-add datapath SHALL be a sub-module mul_seq (start, busy, product, OP_W parameter), instantiated once.

Verification
REQ-024 The bench SHALL cover these directed scenarios (defaults):
- A1=3, A2=5 → after 25 cycles W=15, L=4, STATUS=0x2, gpio_out=1.
- A1=A2=0xFFFFFF → W=0xFFFFFE00, L=24, STATUS=0x6.
- A1=7, A2=9, then an A1=1 write at cycle 3 → W=63, STATUS reads 0xA once, then 0x2.
- A2 write, then n_reset low at cycle 10 → STATUS=0, W=0, gpio_out=0, and no completion follows.
- A2 write, CTRL=1 at cycle 5 → STATUS busy=0 and done=0, gpio_out unchanged; a new A2 write completes normally.
- gpio_in=0xA5A5A5A5, gpio_latch 0→1 → gpio_in_s_insp=0xA5A5A5A5; with gpio_latch held high and gpio_in changed, no update.
